// File: rtl/ui_pkg.sv
// Shared encodings for the multi-line call UI: line states, command opcodes,
// remote event opcodes and a width helper.
package ui_pkg;

  typedef enum logic [2:0] {
    LINE_IDLE     = 3'd0,
    LINE_RINGING  = 3'd1,
    LINE_OUTGOING = 3'd2,
    LINE_ACTIVE   = 3'd3,
    LINE_HELD     = 3'd4
  } line_state_t;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_DIAL      = 3'd1,
    CMD_ACCEPT    = 3'd2,
    CMD_REJECT    = 3'd3,
    CMD_HANGUP    = 3'd4,
    CMD_HOLD      = 3'd5,
    CMD_RESUME    = 3'd6,
    CMD_VOICEMAIL = 3'd7
  } cmd_op_t;

  localparam logic REM_ANSWER = 1'b0;
  localparam logic REM_HANGUP = 1'b1;

  // Ceiling log2, never below 1 so the result is always a legal vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while (r < 31 && (1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/block_list.sv
// Small CAM of blocked caller addresses. Entries fill in order; a duplicate
// or an add while full is ignored, and clear wins over add.
module block_list
  import ui_pkg::*;
#(
  parameter int BLOCK_DEPTH = 8,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              add,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              hit,
  output logic              full
);

  localparam int IW = clog2(BLOCK_DEPTH);
  localparam int CW = clog2(BLOCK_DEPTH + 1);

  logic [ADDR_W-1:0]      entry_reg [BLOCK_DEPTH];
  logic [CW-1:0]          count_reg;
  logic [BLOCK_DEPTH-1:0] add_match;
  logic [BLOCK_DEPTH-1:0] query_match;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_DEPTH; gi++) begin : g_cam
      logic live;
      assign live            = count_reg > CW'(gi);
      assign add_match[gi]   = live && (entry_reg[gi] == addr_in);
      assign query_match[gi] = live && (entry_reg[gi] == query_addr);
    end
  endgenerate

  assign hit  = |query_match;
  assign full = (count_reg == CW'(BLOCK_DEPTH));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (add && !full && !(|add_match)) begin
      entry_reg[count_reg[IW-1:0]] <= addr_in;
      count_reg                    <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/multiline_call_ui.sv
// Multi-line call UI: per-line call state, ring timeout with voicemail
// fallback, call blocking and a single-slot valid/ready command channel.
module multiline_call_ui
  import ui_pkg::*;
#(
  parameter int NUM_LINES    = 4,
  parameter int ADDR_W       = 8,
  parameter int BLOCK_DEPTH  = 8,
  parameter int RING_TIMEOUT = 27000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sys_ready,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_enter,
  input  logic [ADDR_W-1:0]             dial_addr,
  input  logic                          vm_enable,
  input  logic                          block_add,
  input  logic                          block_clear,
  input  logic                          inc_valid,
  output logic                          inc_ready,
  input  logic [clog2(NUM_LINES)-1:0]   inc_line,
  input  logic [ADDR_W-1:0]             inc_addr,
  input  logic                          rem_valid,
  input  logic                          rem_op,
  input  logic [clog2(NUM_LINES)-1:0]   rem_line,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [2:0]                    cmd_op,
  output logic [clog2(NUM_LINES)-1:0]   cmd_line,
  output logic [ADDR_W-1:0]             cmd_addr,
  output logic [clog2(NUM_LINES)-1:0]   focus,
  output logic [3*NUM_LINES-1:0]        line_state,
  output logic                          block_full
);

  localparam int LW = clog2(NUM_LINES);
  localparam int CW = clog2(RING_TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(RING_TIMEOUT - 1);

  logic                 run_reg;
  logic [LW-1:0]        focus_reg, focus_next;
  line_state_t          line_reg [NUM_LINES];
  line_state_t          line_next [NUM_LINES];
  logic [ADDR_W-1:0]    addr_reg [NUM_LINES];
  logic [ADDR_W-1:0]    addr_next [NUM_LINES];
  logic [CW-1:0]        ring_cnt_reg [NUM_LINES];
  logic [NUM_LINES-1:0] ring_restart;

  logic                 cmd_valid_reg;
  cmd_op_t              cmd_op_reg;
  logic [LW-1:0]        cmd_line_reg;
  logic [ADDR_W-1:0]    cmd_addr_reg;

  logic                 slot_free, inc_accept, blk_hit;
  logic                 issue, timeout_hit;
  cmd_op_t              new_op, btn_op;
  logic [LW-1:0]        new_line;
  logic [ADDR_W-1:0]    new_addr;
  line_state_t          focus_state, btn_state;

  block_list #(.BLOCK_DEPTH(BLOCK_DEPTH), .ADDR_W(ADDR_W)) u_block_list (
    .clk        (clk),
    .reset      (reset),
    .add        (block_add),
    .clear      (block_clear),
    .addr_in    (dial_addr),
    .query_addr (inc_addr),
    .hit        (blk_hit),
    .full       (block_full)
  );

  assign slot_free  = !cmd_valid_reg || cmd_ready;
  assign inc_accept = run_reg && !reset && inc_valid && slot_free;
  assign inc_ready  = inc_accept;

  // Sources are applied in priority order to a working copy of the line
  // table, so each lower source sees the effect of the higher ones.
  always_comb begin
    line_next    = line_reg;
    addr_next    = addr_reg;
    ring_restart = '0;
    focus_next   = focus_reg;
    issue        = 1'b0;
    timeout_hit  = 1'b0;
    new_op       = CMD_NONE;
    new_line     = '0;
    new_addr     = '0;
    btn_op       = CMD_NONE;
    btn_state    = LINE_IDLE;
    focus_state  = LINE_IDLE;

    if (rem_valid && int'(rem_line) < NUM_LINES) begin
      if (rem_op == REM_HANGUP) begin
        line_next[rem_line] = LINE_IDLE;
      end else if (line_next[rem_line] == LINE_OUTGOING) begin
        for (int i = 0; i < NUM_LINES; i++)
          if (line_next[i] == LINE_ACTIVE) line_next[i] = LINE_HELD;
        line_next[rem_line] = LINE_ACTIVE;
      end
    end

    if (inc_accept) begin
      if (blk_hit || int'(inc_line) >= NUM_LINES || line_next[inc_line] != LINE_IDLE) begin
        issue    = 1'b1;
        new_op   = CMD_REJECT;
        new_line = inc_line;
        new_addr = inc_addr;
      end else begin
        line_next[inc_line]    = LINE_RINGING;
        addr_next[inc_line]    = inc_addr;
        ring_restart[inc_line] = 1'b1;
      end
    end

    if (run_reg && slot_free && !issue) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (!timeout_hit && !ring_restart[i] && line_reg[i] == LINE_RINGING &&
            line_next[i] == LINE_RINGING && ring_cnt_reg[i] == TMAX) begin
          timeout_hit  = 1'b1;
          issue        = 1'b1;
          new_op       = vm_enable ? CMD_VOICEMAIL : CMD_REJECT;
          new_line     = LW'(i);
          new_addr     = addr_next[i];
          line_next[i] = LINE_IDLE;
        end
      end
    end

    // Only the highest-priority pulse acts; up moves towards higher line numbers.
    if (run_reg) begin
      focus_state = line_next[focus_reg];
      if (btn_enter) begin
        case (focus_state)
          LINE_IDLE:    begin btn_op = CMD_DIAL;   btn_state = LINE_OUTGOING; end
          LINE_RINGING: begin btn_op = CMD_ACCEPT; btn_state = LINE_ACTIVE;   end
          LINE_ACTIVE:  begin btn_op = CMD_HANGUP; btn_state = LINE_IDLE;     end
          LINE_HELD:    begin btn_op = CMD_HANGUP; btn_state = LINE_IDLE;     end
          default: ;
        endcase
      end else if (btn_right) begin
        case (focus_state)
          LINE_RINGING: begin btn_op = CMD_ACCEPT; btn_state = LINE_ACTIVE; end
          LINE_ACTIVE:  begin btn_op = CMD_HOLD;   btn_state = LINE_HELD;   end
          LINE_HELD:    begin btn_op = CMD_RESUME; btn_state = LINE_ACTIVE; end
          default: ;
        endcase
      end else if (btn_left) begin
        case (focus_state)
          LINE_RINGING:  begin btn_op = CMD_REJECT; btn_state = LINE_IDLE; end
          LINE_OUTGOING: begin btn_op = CMD_HANGUP; btn_state = LINE_IDLE; end
          default: ;
        endcase
      end else if (btn_up) begin
        focus_next = (focus_reg == LW'(NUM_LINES - 1)) ? '0 : focus_reg + 1'b1;
      end else if (btn_down) begin
        focus_next = (focus_reg == '0) ? LW'(NUM_LINES - 1) : focus_reg - 1'b1;
      end

      if (btn_op != CMD_NONE && slot_free && !issue) begin
        if (btn_state == LINE_ACTIVE)
          for (int i = 0; i < NUM_LINES; i++)
            if (line_next[i] == LINE_ACTIVE) line_next[i] = LINE_HELD;
        line_next[focus_reg] = btn_state;
        if (btn_op == CMD_DIAL) addr_next[focus_reg] = dial_addr;
        issue    = 1'b1;
        new_op   = btn_op;
        new_line = focus_reg;
        new_addr = addr_next[focus_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_reg       <= 1'b0;
      focus_reg     <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_op_reg    <= CMD_NONE;
      cmd_line_reg  <= '0;
      cmd_addr_reg  <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        line_reg[i]     <= LINE_IDLE;
        addr_reg[i]     <= '0;
        ring_cnt_reg[i] <= '0;
      end
    end else begin
      if (sys_ready) run_reg <= 1'b1;
      focus_reg <= focus_next;
      for (int i = 0; i < NUM_LINES; i++) begin
        line_reg[i] <= line_next[i];
        addr_reg[i] <= addr_next[i];
        // Counter saturates at TMAX so a timeout stuck behind a busy slot stays pending.
        if (line_reg[i] == LINE_RINGING && line_next[i] == LINE_RINGING && !ring_restart[i])
          ring_cnt_reg[i] <= (ring_cnt_reg[i] == TMAX) ? ring_cnt_reg[i] : ring_cnt_reg[i] + 1'b1;
        else
          ring_cnt_reg[i] <= '0;
      end
      if (issue) begin
        cmd_valid_reg <= 1'b1;
        cmd_op_reg    <= new_op;
        cmd_line_reg  <= new_line;
        cmd_addr_reg  <= new_addr;
      end else if (cmd_valid_reg && cmd_ready) begin
        cmd_valid_reg <= 1'b0;
      end
    end
  end

  assign cmd_valid = cmd_valid_reg;
  assign cmd_op    = cmd_op_reg;
  assign cmd_line  = cmd_line_reg;
  assign cmd_addr  = cmd_addr_reg;
  assign focus     = focus_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_state
      assign line_state[gi*3 +: 3] = line_reg[gi];
    end
  endgenerate

endmodule

// File: doc/multiline_call_ui.md
Name: multiline_call_ui

Overview:
- Parametrised successor to the single-call UI FSM in the telephony node.
- Tracks NUM_LINES independent call lines, each with its own state machine; buttons act on the focused line.
- Adds a ring timeout with voicemail fallback, a call-block list, and a valid/ready command channel to the application layer.
- Sits between the debounced button/switch front end and the application/network layer.

Parameters:
- NUM_LINES, 4, number of simultaneous call lines (2..8)
- ADDR_W, 8, node address width
- BLOCK_DEPTH, 8, call-block list entries
- RING_TIMEOUT, 27000000, cycles a line may ring before auto-disposition (1 s at 27 MHz)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sys_ready  in  1  network initialised
- btn_up, btn_down, btn_left, btn_right, btn_enter  in  1 each  single-cycle debounced pulses
- dial_addr  in  ADDR_W  switch-entered address
- vm_enable  in  1  send unanswered calls to voicemail
- block_add, block_clear  in  1 each  pulses; add dial_addr to / clear block list
- inc_valid  in  1  incoming call offered
- inc_ready  out  1  incoming call accepted this cycle
- inc_line  in  clog2(NUM_LINES)  target line
- inc_addr  in  ADDR_W  caller address
- rem_valid  in  1  remote event
- rem_op  in  1  0=ANSWER, 1=HANGUP
- rem_line  in  clog2(NUM_LINES)  line of remote event
- cmd_valid  out  1  command pending
- cmd_ready  in  1  application accepts command
- cmd_op  out  3  DIAL=1, ACCEPT=2, REJECT=3, HANGUP=4, HOLD=5, RESUME=6, VOICEMAIL=7
- cmd_line  out  clog2(NUM_LINES)
- cmd_addr  out  ADDR_W
- focus  out  clog2(NUM_LINES)  focused line
- line_state  out  3*NUM_LINES  packed per-line state
- block_full  out  1  block list full

Behaviour:
- Reset values: all outputs 0, every line IDLE, focus 0, block list empty, ring counters 0.
- Global mode: INIT until sys_ready is seen high, then RUN permanently. While in INIT, buttons are ignored and inc_ready=0.
- Line states: IDLE=0, RINGING=1, OUTGOING=2, ACTIVE=3, HELD=4. At most one line is ACTIVE at a time.
- Command slot: a single register. cmd_* hold stable while cmd_valid && !cmd_ready. The slot is free when !cmd_valid or the cmd_ready handshake completes this cycle. At most one new command is issued per cycle.
- Per-cycle priority: remote event > incoming > ring timeout > button.
- Only one of incoming, timeout or button may issue a command in a cycle. A lower-priority source that needs the slot:
  - incoming: waits with inc_ready=0;
  - timeout: stays pending;
  - button: is dropped.
- Remote events need no command and are always applied:
  - ANSWER on an OUTGOING line -> ACTIVE; the previously ACTIVE line -> HELD.
  - HANGUP on any line -> IDLE.
  - Any other remote event is ignored.
- Incoming (inc_valid && slot free): inc_ready=1 for that cycle.
  - inc_addr is in the block list, or the target line is not IDLE -> REJECT issued; line unchanged.
  - Otherwise -> line RINGING, its ring counter cleared.
- Ring timeout: a RINGING line reaching count RING_TIMEOUT-1 issues VOICEMAIL if vm_enable, else REJECT; the line goes IDLE when the command is issued. The counter saturates while waiting for the slot.
- Button actions on the focused line:
  - up/down move focus with wrap (NUM_LINES-1 <-> 0).
  - IDLE + enter: DIAL with dial_addr; line -> OUTGOING.
  - RINGING + enter/right: ACCEPT; line -> ACTIVE; any other ACTIVE line -> HELD locally (the application implies the hold).
  - RINGING + left: REJECT; line -> IDLE.
  - OUTGOING + left: HANGUP; line -> IDLE.
  - ACTIVE + enter: HANGUP; line -> IDLE.
  - ACTIVE + right: HOLD; line -> HELD.
  - HELD + right: RESUME; line -> ACTIVE; the other ACTIVE line -> HELD.
  - HELD + enter: HANGUP; line -> IDLE.
  - All other combinations: no effect.
- Simultaneous button pulses: priority enter > right > left > up > down.
- Block list:
  - block_add of an address already present makes no change.
  - block_add when full is ignored; block_full=1.
  - block_clear has priority over block_add in the same cycle.
  - Lookup is combinational and uses the current contents.
- A reset mid-handshake drops the pending command.

Decomposition:
- Package ui_pkg: cmd_op encodings, line state encodings, rem_op encodings, clog2 function.
- Sub-module block_list: parametrised CAM with BLOCK_DEPTH entries x ADDR_W. Ports: add, clear, addr_in, query_addr, hit, full.

Test Plan:
- Init gating: sys_ready=0, btn_enter pulse -> cmd_valid stays 0; sys_ready=1, then dial_addr=0x2A + enter -> cmd_op=1, cmd_addr=0x2A, line0=OUTGOING.
- Answer/hold/resume: rem ANSWER on line0 -> ACTIVE. Incoming 0x11 on line1, focus=1, enter -> ACCEPT; line1=ACTIVE, line0=HELD. focus=0, right -> RESUME; line0=ACTIVE, line1=HELD.
- Timeout: RING_TIMEOUT=16, vm_enable=1, incoming on line2 with no press -> VOICEMAIL issued at cycle 16, line2=IDLE. Repeat with vm_enable=0 -> REJECT.
- Blocking: add 0x33 eight times plus 0x34..0x3B -> block_full=1, 0x3B absent. Incoming 0x33 -> REJECT, line stays IDLE.
- Backpressure: cmd_ready=0 with a pending DIAL, inc_valid=1 -> inc_ready=0 and cmd_* stable. cmd_ready=1 -> DIAL handshake completes, next cycle inc_ready=1.
- Busy line: incoming to an ACTIVE line -> REJECT; reset mid-ringing -> all lines IDLE and cmd_valid=0 the next cycle.
